fma_issue_queue: RTL and testbench

FMA_ISSUE_QUEUE -- requirements
Module: fma_issue_queue

---
 rtl/fma_issue_queue.sv | 149 ++++++++++++++
 tb/tb_fma_issue_queue.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_issue_queue.sv
// fma_issue_queue: operand FIFO feeding a fixed-latency external FMA pipeline.
// A valid/tag delay line runs alongside the pipeline so each result leaves
// with the tag of the operation that produced it.
module fma_issue_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned FMA_LAT = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  in_a,
    input  logic [31:0]                  in_b,
    input  logic [31:0]                  in_c,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         issue_hold,
    output logic [31:0]                  fma_a,
    output logic [31:0]                  fma_b,
    output logic [31:0]                  fma_c,
    input  logic [31:0]                  fma_result,
    output logic                         out_valid,
    output logic [31:0]                  out_result,
    output logic [TAG_W-1:0]             out_tag,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic [$clog2(FMA_LAT+2)-1:0] inflight,
    output logic [15:0]                  done_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned InfW = $clog2(FMA_LAT + 2);

    logic [31:0]      mem_a [DEPTH];
    logic [31:0]      mem_b [DEPTH];
    logic [31:0]      mem_c [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            push, pop;

    logic [31:0] fma_a_q, fma_b_q, fma_c_q;

    // Stage 0 lines up with operands on fma_*; stage FMA_LAT with the result.
    logic [FMA_LAT:0] vld_q;
    logic [TAG_W-1:0] tag_q [FMA_LAT+1];
    logic [15:0]      done_q;
    logic [InfW-1:0]  inflight_sum;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
    assign in_ready = (count_q < CntW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !issue_hold;

    // Occupancy next-state: push and pop together cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers; power-of-two depth makes the wrap implicit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q]   <= in_a;
            mem_b[wr_ptr_q]   <= in_b;
            mem_c[wr_ptr_q]   <= in_c;
            mem_tag[wr_ptr_q] <= in_tag;
        end
    end

    // Issue register: popped operands, or an all-zero bubble when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fma_a_q <= '0;
            fma_b_q <= '0;
            fma_c_q <= '0;
        end else if (pop) begin
            fma_a_q <= mem_a[rd_ptr_q];
            fma_b_q <= mem_b[rd_ptr_q];
            fma_c_q <= mem_c[rd_ptr_q];
        end else begin
            fma_a_q <= '0;
            fma_b_q <= '0;
            fma_c_q <= '0;
        end
    end

    // Valid/tag delay line shadowing the FMA pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i <= int'(FMA_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= {vld_q[FMA_LAT-1:0], pop};
            tag_q[0] <= pop ? mem_tag[rd_ptr_q] : '0;
            for (int i = 1; i <= int'(FMA_LAT); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Completed-beat counter, free-running wrap at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= '0;
        end else if (out_valid) begin
            done_q <= done_q + 16'd1;
        end
    end

    // In-flight count: every issued bit still in the delay line, output cycle included.
    always_comb begin
        inflight_sum = '0;
        for (int i = 0; i <= int'(FMA_LAT); i++) begin
            inflight_sum = inflight_sum + InfW'(vld_q[i]);
        end
    end

    assign fma_a      = fma_a_q;
    assign fma_b      = fma_b_q;
    assign fma_c      = fma_c_q;
    assign out_valid  = vld_q[FMA_LAT];
    assign out_tag    = tag_q[FMA_LAT];
    assign out_result = out_valid ? fma_result : 32'h0;
    assign fifo_count = count_q;
    assign inflight   = inflight_sum;
    assign done_cnt   = done_q;

endmodule

// File: tb/tb_fma_issue_queue.sv
// Directed bench for fma_issue_queue with a behavioural FMA pipeline stand-in.
module tb_fma_issue_queue;

    localparam int DEPTH   = 4;
    localparam int FMA_LAT = 3;
    localparam int TAG_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       in_a, in_b, in_c;
    logic [TAG_W-1:0]  in_tag;
    logic              in_valid, in_ready, issue_hold;
    logic [31:0]       fma_a, fma_b, fma_c, fma_result;
    logic              out_valid;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic [2:0]        fifo_count;
    logic [2:0]        inflight;
    logic [15:0]       done_cnt;

    int checks   = 0;
    int failures = 0;

    fma_issue_queue #(.DEPTH(DEPTH), .FMA_LAT(FMA_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_tag(in_tag),
        .in_valid(in_valid), .in_ready(in_ready), .issue_hold(issue_hold),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_result(fma_result),
        .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag),
        .fifo_count(fifo_count), .inflight(inflight), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // FMA stand-in: knows the two test vectors, returns a marker for anything else.
    function automatic logic [31:0] fma_model(input logic [31:0] a, b, c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000) return 32'h40A00000;
        if (a == 32'h3F800000 && b == 32'h41F00000 && c == 32'hC1A00000) return 32'h41200000;
        return 32'hBAD0BAD0;
    endfunction

    logic [31:0] pa [FMA_LAT];
    logic [31:0] pb [FMA_LAT];
    logic [31:0] pc [FMA_LAT];

    always @(posedge clk) begin
        for (int i = FMA_LAT - 1; i >= 0; i--) begin
            if (rst) begin
                pa[i] <= '0; pb[i] <= '0; pc[i] <= '0;
            end else if (i == 0) begin
                pa[0] <= fma_a; pb[0] <= fma_b; pc[0] <= fma_c;
            end else begin
                pa[i] <= pa[i-1]; pb[i] <= pb[i-1]; pc[i] <= pc[i-1];
            end
        end
    end

    assign fma_result = fma_model(pa[FMA_LAT-1], pb[FMA_LAT-1], pc[FMA_LAT-1]);

    // Output beat monitor.
    typedef struct {
        int               cyc;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } beat_t;

    beat_t beats[$];
    int    cyc    = 0;
    int    nbeats = 0;
    bit    record = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            nbeats++;
            if (record) beats.push_back('{cyc: cyc, tag: out_tag, res: out_result});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // sel 0: 1*2+3 = 5; sel 1: 1*30-20 = 10
    task automatic drive(input bit sel, input logic [TAG_W-1:0] tag);
        in_a     = 32'h3F800000;
        in_b     = sel ? 32'h41F00000 : 32'h40000000;
        in_c     = sel ? 32'hC1A00000 : 32'h40400000;
        in_tag   = tag;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; issue_hold = 1'b0;
        in_a = '0; in_b = '0; in_c = '0; in_tag = '0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        checks++; if (inflight !== 3'd0) begin failures++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
        checks++; if (done_cnt !== 16'd0) begin failures++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt); end
        checks++; if (fma_a !== 32'h0) begin failures++; $display("FAIL reset_fma_a: got %h want 0", fma_a); end
        checks++; if (out_tag !== 4'd0) begin failures++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        drive(1'b0, 4'd1);
        tick();
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        checks++; if (fma_a !== 32'h0) begin failures++; $display("FAIL single_no_bypass: got %h want 0", fma_a); end
        tick();
        checks++; if (fma_a !== 32'h3F800000 || fma_b !== 32'h40000000 || fma_c !== 32'h40400000) begin
            failures++; $display("FAIL single_fma_ops: got %h %h %h want 3f800000 40000000 40400000", fma_a, fma_b, fma_c);
        end
        checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL single_inflight: got %0d want 1", inflight); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin
            failures++; $display("FAIL single_early: got valid %b result %h want 0 0", out_valid, out_result);
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early2: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h40A00000 || out_tag !== 4'd1) begin
            failures++; $display("FAIL single_beat: got v%b %h tag %0d want v1 40a00000 tag 1", out_valid, out_result, out_tag);
        end
        checks++; if (inflight !== 3'd1) begin failures++; $display("FAIL single_inflight_out: got %0d want 1", inflight); end
        tick();
        checks++; if (out_valid !== 1'b0 || done_cnt !== 16'd1 || inflight !== 3'd0) begin
            failures++; $display("FAIL single_after: got v%b done %0d infl %0d want v0 done 1 infl 0", out_valid, done_cnt, inflight);
        end
    endtask

    task automatic test_back_to_back();
        beats.delete(); record = 1'b1;
        drive(1'b1, 4'd2);
        tick();
        drive(1'b0, 4'd3);
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        record = 1'b0;
        checks++;
        if (beats.size() != 2) begin
            failures++; $display("FAIL b2b_beats: got %0d want 2", beats.size());
        end else begin
            checks++; if (beats[1].cyc - beats[0].cyc != 1) begin failures++; $display("FAIL b2b_consecutive: got gap %0d want 1", beats[1].cyc - beats[0].cyc); end
            checks++; if (beats[0].tag !== 4'd2 || beats[0].res !== 32'h41200000) begin
                failures++; $display("FAIL b2b_first: got tag %0d %h want tag 2 41200000", beats[0].tag, beats[0].res);
            end
            checks++; if (beats[1].tag !== 4'd3 || beats[1].res !== 32'h40A00000) begin
                failures++; $display("FAIL b2b_second: got tag %0d %h want tag 3 40a00000", beats[1].tag, beats[1].res);
            end
        end
        checks++; if (done_cnt !== 16'd3) begin failures++; $display("FAIL b2b_done_cnt: got %0d want 3", done_cnt); end
    endtask

    task automatic test_full();
        int idx = 0;
        bit rdy;
        logic [TAG_W-1:0] t;
        beats.delete(); record = 1'b1;
        issue_hold = 1'b1;
        drive(1'b0, 4'd4);
        for (int i = 0; i < 7; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) idx++;
            t = TAG_W'(4 + idx);
            drive(t[0], t);
        end
        checks++; if (idx != 4) begin failures++; $display("FAIL full_accepts: got %0d want 4", idx); end
        checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
            failures++; $display("FAIL full_state: got count %0d ready %b want 4 0", fifo_count, in_ready);
        end
        issue_hold = 1'b0;
        rdy = in_ready;
        tick();
        if (rdy) idx++;
        checks++; if (idx != 4 || fifo_count !== 3'd3) begin
            failures++; $display("FAIL full_pop_no_push: got accepts %0d count %0d want 4 3", idx, fifo_count);
        end
        rdy = in_ready;
        tick();
        if (rdy) idx++;
        in_valid = 1'b0;
        checks++; if (idx != 5 || fifo_count !== 3'd3) begin
            failures++; $display("FAIL full_fifth: got accepts %0d count %0d want 5 3", idx, fifo_count);
        end
        repeat (10) tick();
        record = 1'b0;
        checks++;
        if (beats.size() != 5) begin
            failures++; $display("FAIL full_beats: got %0d want 5", beats.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                t = TAG_W'(4 + i);
                checks++;
                if (beats[i].tag !== t || beats[i].res !== (t[0] ? 32'h41200000 : 32'h40A00000)) begin
                    failures++; $display("FAIL full_beat%0d: got tag %0d %h want tag %0d %h", i, beats[i].tag,
                                         beats[i].res, t, t[0] ? 32'h41200000 : 32'h40A00000);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic [5:0] pat = 6'b001100;
        logic [TAG_W-1:0] t;
        beats.delete(); record = 1'b1;
        issue_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = TAG_W'(i);
            drive(t[0], t);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL hold_fill: got %0d want 4", fifo_count); end
        for (int i = 0; i < 6; i++) begin
            issue_hold = pat[i];
            tick();
            checks++;
            if (fma_a !== (pat[i] ? 32'h0 : 32'h3F800000)) begin
                failures++; $display("FAIL hold_fma_a%0d: got %h want %h", i, fma_a, pat[i] ? 32'h0 : 32'h3F800000);
            end
        end
        repeat (8) tick();
        record = 1'b0;
        checks++;
        if (beats.size() != 4) begin
            failures++; $display("FAIL hold_beats: got %0d want 4", beats.size());
        end else begin
            checks++;
            if (beats[1].cyc - beats[0].cyc != 1 || beats[2].cyc - beats[1].cyc != 3 ||
                beats[3].cyc - beats[2].cyc != 1) begin
                failures++; $display("FAIL hold_gaps: got %0d %0d %0d want 1 3 1", beats[1].cyc - beats[0].cyc,
                                     beats[2].cyc - beats[1].cyc, beats[3].cyc - beats[2].cyc);
            end
            for (int i = 0; i < 4; i++) begin
                t = TAG_W'(i);
                checks++;
                if (beats[i].tag !== t || beats[i].res !== (t[0] ? 32'h41200000 : 32'h40A00000)) begin
                    failures++; $display("FAIL hold_beat%0d: got tag %0d %h want tag %0d", i, beats[i].tag, beats[i].res, t);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        issue_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, TAG_W'(8 + i));
            tick();
        end
        in_valid = 1'b0;
        issue_hold = 1'b0;
        tick();
        tick();
        issue_hold = 1'b1;
        checks++; if (fifo_count !== 3'd2 || inflight !== 3'd2) begin
            failures++; $display("FAIL rmid_setup: got count %0d infl %0d want 2 2", fifo_count, inflight);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (fifo_count !== 3'd0 || inflight !== 3'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_clear: got count %0d infl %0d valid %b want 0 0 0", fifo_count, inflight, out_valid);
        end
        checks++; if (fma_a !== 32'h0 || done_cnt !== 16'd0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
            failures++; $display("FAIL rmid_outputs: got fma_a %h done %0d ready %b res %h want 0 0 1 0", fma_a, done_cnt, in_ready, out_result);
        end
        tick();
        rst = 1'b0;
        issue_hold = 1'b0;
        n0 = nbeats;
        repeat (10) tick();
        checks++; if (nbeats != n0 || done_cnt !== 16'd0) begin
            failures++; $display("FAIL rmid_stale: got beats %0d done %0d want 0 0", nbeats - n0, done_cnt);
        end
        drive(1'b0, 4'd5);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        checks++; if (nbeats != n0 + 1 || done_cnt !== 16'd1) begin
            failures++; $display("FAIL rmid_resume: got beats %0d done %0d want 1 1", nbeats - n0, done_cnt);
        end
    endtask

    task automatic test_wrap();
        int accepted = 0;
        int n0;
        bit rdy;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n0 = nbeats;
        drive(1'b0, 4'd7);
        for (int i = 0; i < 70000 && accepted < 65537; i++) begin
            rdy = in_ready;
            tick();
            if (rdy) accepted++;
        end
        in_valid = 1'b0;
        repeat (10) tick();
        checks++; if (accepted != 65537) begin failures++; $display("FAIL wrap_accepts: got %0d want 65537", accepted); end
        checks++; if (nbeats - n0 != 65537) begin failures++; $display("FAIL wrap_beats: got %0d want 65537", nbeats - n0); end
        checks++; if (done_cnt !== 16'd1) begin failures++; $display("FAIL wrap_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (fifo_count !== 3'd0 || inflight !== 3'd0) begin
            failures++; $display("FAIL wrap_idle: got count %0d infl %0d want 0 0", fifo_count, inflight);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_hold();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
